// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a word-wide synchronous RAM with 1-cycle read latency.
// Handles byte/half/word lanes and sign/zero extension, and splits word-crossing accesses into two RAM cycles.
module data_mem_lsu #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  memWrite_en_i,
  input  logic [1:0]            memType_i,
  input  logic                  memSign_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [31:0]           rdata_o,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int WW = ADDR_WIDTH - 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [WW-1:0] r_addr_word;
  logic [WW-1:0] w_addr_inc;
  logic [1:0]    r_off;
  logic [1:0]    r_type;
  logic          r_sign;
  logic          r_cross;
  logic          r_misalign;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_wdata_hi;
  logic [31:0]   r_buf;
  logic [31:0]   r_rdata;

  logic [1:0]    w_off;
  logic          w_cross;
  logic          w_illegal;
  logic          w_reject;
  logic [7:0]    w_mask8;
  logic [7:0]    w_be8;
  logic [63:0]   w_wd64;

  // Shift the selected lanes of a two-word window down to bit 0 and extend.
  function automatic logic [31:0] f_extend(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] typ, input logic sgn);
    logic [63:0] sh;
    sh = pair >> {off, 3'b000};
    case (typ)
      2'b01:   f_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b10:   f_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: f_extend = sh[31:0];
    endcase
  endfunction

  assign w_off      = addr_i[1:0];
  assign w_cross    = ((memType_i == 2'b10) && (w_off == 2'd3)) ||
                      ((memType_i == 2'b00) && (w_off != 2'd0));
  assign w_illegal  = (memType_i == 2'b11);
  assign w_reject   = w_illegal || (w_cross && !MISALIGN_EN);
  assign w_be8      = w_mask8 << w_off;
  assign w_wd64     = {32'h0000_0000, wdata_i} << {w_off, 3'b000};
  assign w_addr_inc = r_addr_word + {{(WW-1){1'b0}}, 1'b1};

  assign done_o     = (r_state == S_RESP);
  assign misalign_o = (r_state == S_RESP) && r_misalign;
  assign rdata_o    = r_rdata;

  // Lane mask for the access size before shifting by the byte offset.
  always_comb begin
    case (memType_i)
      2'b00:   w_mask8 = 8'h0F;
      2'b01:   w_mask8 = 8'h01;
      2'b10:   w_mask8 = 8'h03;
      default: w_mask8 = 8'h00;
    endcase
  end

  // Next state and RAM-side strobes; the first RAM cycle is driven straight from the request.
  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    ram_wdata_o = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          stall_o    = 1'b1;
          ram_addr_o = addr_i[ADDR_WIDTH-1:2];
          if (w_reject) begin
            w_state_nxt = S_RESP;
          end else if (memWrite_en_i) begin
            ram_we_o    = 1'b1;
            ram_be_o    = w_be8[3:0];
            ram_wdata_o = w_wd64[31:0];
            w_state_nxt = w_cross ? S_WR1 : S_RESP;
          end else begin
            w_state_nxt = S_RD0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD0: begin
        stall_o     = 1'b1;
        ram_addr_o  = r_cross ? w_addr_inc : r_addr_word;
        w_state_nxt = r_cross ? S_RD1 : S_RESP;
      end
      S_RD1: begin
        stall_o     = 1'b1;
        ram_addr_o  = w_addr_inc;
        w_state_nxt = S_RESP;
      end
      S_WR1: begin
        stall_o     = 1'b1;
        ram_addr_o  = w_addr_inc;
        ram_we_o    = 1'b1;
        ram_be_o    = r_be_hi;
        ram_wdata_o = r_wdata_hi;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, request latch and load-result assembly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_addr_word <= '0;
      r_off       <= 2'b00;
      r_type      <= 2'b00;
      r_sign      <= 1'b0;
      r_cross     <= 1'b0;
      r_misalign  <= 1'b0;
      r_be_hi     <= 4'b0000;
      r_wdata_hi  <= 32'h0000_0000;
      r_buf       <= 32'h0000_0000;
      r_rdata     <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_addr_word <= addr_i[ADDR_WIDTH-1:2];
            r_off       <= w_off;
            r_type      <= memType_i;
            r_sign      <= memSign_i;
            r_cross     <= w_cross;
            r_misalign  <= w_cross && !MISALIGN_EN;
            r_be_hi     <= w_be8[7:4];
            r_wdata_hi  <= w_wd64[63:32];
          end
        end
        S_RD0: begin
          r_buf <= ram_rdata_i;
          if (!r_cross) begin
            r_rdata <= f_extend({32'h0000_0000, ram_rdata_i}, r_off, r_type, r_sign);
          end
        end
        S_RD1: begin
          r_rdata <= f_extend({ram_rdata_i, r_buf}, r_off, r_type, r_sign);
        end
        S_RESP: begin
          r_misalign <= 1'b0;
        end
        default: begin
          r_misalign <= r_misalign;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one instance splits crossing accesses, a second rejects them.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b;
  logic        we_en;
  logic [1:0]  mtype;
  logic        msign;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        stall_a, done_a, mis_a, ramwe_a;
  logic [31:0] rdata_a, ramwd_a, ramrd_a;
  logic [29:0] ramad_a;
  logic [3:0]  rambe_a;
  logic        stall_b, done_b, mis_b, ramwe_b;
  logic [31:0] rdata_b, ramwd_b, ramrd_b;
  logic [29:0] ramad_b;
  logic [3:0]  rambe_b;

  logic [31:0] mem_a [logic [29:0]];
  logic [31:0] mem_b [logic [29:0]];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.ADDR_WIDTH(32), .MISALIGN_EN(1'b1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .memWrite_en_i(we_en), .memType_i(mtype),
    .memSign_i(msign), .addr_i(addr), .wdata_i(wdata), .stall_o(stall_a), .done_o(done_a),
    .rdata_o(rdata_a), .misalign_o(mis_a), .ram_addr_o(ramad_a), .ram_we_o(ramwe_a),
    .ram_be_o(rambe_a), .ram_wdata_o(ramwd_a), .ram_rdata_i(ramrd_a));

  data_mem_lsu #(.ADDR_WIDTH(32), .MISALIGN_EN(1'b0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .memWrite_en_i(we_en), .memType_i(mtype),
    .memSign_i(msign), .addr_i(addr), .wdata_i(wdata), .stall_o(stall_b), .done_o(done_b),
    .rdata_o(rdata_b), .misalign_o(mis_b), .ram_addr_o(ramad_b), .ram_we_o(ramwe_b),
    .ram_be_o(rambe_b), .ram_wdata_o(ramwd_b), .ram_rdata_i(ramrd_b));

  // Byte-enabled synchronous RAMs with 1-cycle read latency.
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem_a.exists(ramad_a) ? mem_a[ramad_a] : 32'h0;
    ramrd_a <= w;
    if (ramwe_a) begin
      for (int i = 0; i < 4; i++) if (rambe_a[i]) w[8*i +: 8] = ramwd_a[8*i +: 8];
      mem_a[ramad_a] = w;
    end
    w = mem_b.exists(ramad_b) ? mem_b[ramad_b] : 32'h0;
    ramrd_b <= w;
    if (ramwe_b) begin
      for (int i = 0; i < 4; i++) if (rambe_b[i]) w[8*i +: 8] = ramwd_b[8*i +: 8];
      mem_b[ramad_b] = w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit sel_b, input logic w, input logic [1:0] t, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we_en = w; mtype = t; msign = s; addr = a; wdata = d;
    req_a = !sel_b; req_b = sel_b;
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we_en = 1'b0;
    mtype = 2'b00; msign = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'h0, stall_a}, 32'h0);
    chk("rst_done", {31'h0, done_a}, 32'h0);
    chk("rst_mis", {31'h0, mis_a}, 32'h0);
    chk("rst_we", {31'h0, ramwe_a}, 32'h0);
    chk("rst_be", {28'h0, rambe_a}, 32'h0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_addr", {2'b00, ramad_a}, 32'h0);
    rst_n = 1'b1;

    // aligned store
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("sw_we", {31'h0, ramwe_a}, 32'h1);
    chk("sw_addr", {2'b00, ramad_a}, 32'h40);
    chk("sw_be", {28'h0, rambe_a}, 32'hF);
    chk("sw_wdata", ramwd_a, 32'hDEAD_BEEF);
    chk("sw_stall0", {31'h0, stall_a}, 32'h1);
    chk("sw_done0", {31'h0, done_a}, 32'h0);
    nxt();
    chk("sw_done1", {31'h0, done_a}, 32'h1);
    chk("sw_stall1", {31'h0, stall_a}, 32'h0);
    chk("sw_we1", {31'h0, ramwe_a}, 32'h0);
    nxt();
    chk("sw_done2", {31'h0, done_a}, 32'h0);

    // aligned load of the same word
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0);
    chk("lw_we", {31'h0, ramwe_a}, 32'h0);
    chk("lw_addr", {2'b00, ramad_a}, 32'h40);
    nxt();
    chk("lw_done1", {31'h0, done_a}, 32'h0);
    chk("lw_stall1", {31'h0, stall_a}, 32'h1);
    nxt();
    chk("lw_done2", {31'h0, done_a}, 32'h1);
    chk("lw_rdata", rdata_a, 32'hDEAD_BEEF);
    nxt();

    // byte loads, signed and unsigned, from 0x80FF_0000
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h80FF_0000);
    nxt(); nxt();
    issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0);
    nxt(); nxt();
    chk("lb_done", {31'h0, done_a}, 32'h1);
    chk("lb_rdata", rdata_a, 32'hFFFF_FF80);
    nxt();
    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0);
    nxt(); nxt();
    chk("lbu_rdata", rdata_a, 32'h0000_0080);
    nxt();

    // byte stores building a crossing halfword
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0000_00AA);
    chk("sb3_be", {28'h0, rambe_a}, 32'h8);
    chk("sb3_wdata", ramwd_a & 32'hFF00_0000, 32'hAA00_0000);
    nxt(); nxt();
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0104, 32'h0000_0055);
    chk("sb4_addr", {2'b00, ramad_a}, 32'h41);
    chk("sb4_be", {28'h0, rambe_a}, 32'h1);
    nxt(); nxt();

    // crossing halfword load: words 0x40 then 0x41
    issue(1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0);
    chk("lhx_addr0", {2'b00, ramad_a}, 32'h40);
    nxt();
    chk("lhx_addr1", {2'b00, ramad_a}, 32'h41);
    chk("lhx_stall1", {31'h0, stall_a}, 32'h1);
    nxt();
    chk("lhx_done2", {31'h0, done_a}, 32'h0);
    nxt();
    chk("lhx_done3", {31'h0, done_a}, 32'h1);
    chk("lhx_rdata", rdata_a, 32'h0000_55AA);
    nxt();

    // aligned signed halfword from 0xAAFF_0000
    issue(1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0102, 32'h0);
    nxt(); nxt();
    chk("lh_rdata", rdata_a, 32'hFFFF_AAFF);
    nxt();

    // crossing word store
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h1122_3344);
    chk("swx_be0", {28'h0, rambe_a}, 32'hC);
    chk("swx_wd0", ramwd_a & 32'hFFFF_0000, 32'h3344_0000);
    nxt();
    chk("swx_addr1", {2'b00, ramad_a}, 32'h41);
    chk("swx_we1", {31'h0, ramwe_a}, 32'h1);
    chk("swx_be1", {28'h0, rambe_a}, 32'h3);
    chk("swx_wd1", ramwd_a & 32'h0000_FFFF, 32'h0000_1122);
    nxt();
    chk("swx_done2", {31'h0, done_a}, 32'h1);
    nxt();

    // crossing word load of the same data
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0);
    nxt(); nxt();
    chk("lwx_done2", {31'h0, done_a}, 32'h0);
    nxt();
    chk("lwx_rdata", rdata_a, 32'h1122_3344);
    nxt();

    // word address wrap on both store and load
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    chk("wrs_addr0", {2'b00, ramad_a}, 32'h3FFF_FFFF);
    nxt();
    chk("wrs_addr1", {2'b00, ramad_a}, 32'h0);
    nxt(); nxt();
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0);
    nxt();
    chk("wrl_addr1", {2'b00, ramad_a}, 32'h0);
    nxt(); nxt();
    chk("wrl_rdata", rdata_a, 32'hCAFE_F00D);
    nxt();

    // rejecting instance: crossing word load and illegal type
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0);
    chk("rej_we", {31'h0, ramwe_b}, 32'h0);
    chk("rej_be", {28'h0, rambe_b}, 32'h0);
    chk("rej_stall", {31'h0, stall_b}, 32'h1);
    nxt();
    chk("rej_done", {31'h0, done_b}, 32'h1);
    chk("rej_mis", {31'h0, mis_b}, 32'h1);
    nxt();
    chk("rej_mis_off", {31'h0, mis_b}, 32'h0);
    issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h1234_5678);
    chk("ill_we", {31'h0, ramwe_b}, 32'h0);
    chk("ill_be", {28'h0, rambe_b}, 32'h0);
    nxt();
    chk("ill_done", {31'h0, done_b}, 32'h1);
    chk("ill_mis", {31'h0, mis_b}, 32'h0);
    nxt();

    // reset while the second half of a crossing store is on the bus
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0106, 32'h1122_3344);
    nxt();
    chk("rwr_we1", {31'h0, ramwe_a}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rwr_we_drop", {31'h0, ramwe_a}, 32'h0);
    chk("rwr_stall", {31'h0, stall_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rwr_nodone", {31'h0, done_a}, 32'h0);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_005A);
    chk("rsb_be", {28'h0, rambe_a}, 32'h2);
    chk("rsb_wd", ramwd_a & 32'h0000_FF00, 32'h0000_5A00);
    nxt();
    chk("rsb_done", {31'h0, done_a}, 32'h1);
    nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
